// File: rtl/boot_loader_pkg.sv
// Shared definitions for the UART boot loader: protocol constants, field
// widths and the state encodings of the protocol FSM and serial receiver.
package boot_loader_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         WORD_W     = 32;
    localparam int         BYTE_W     = 8;
    localparam int         LEN_BYTES  = 4;
    localparam int         WORD_BYTES = 4;
    localparam int         CSUM_W     = 8;
    localparam logic [WORD_W-1:0] ADDR_STEP = 32'd4;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver: input synchronizer, half-bit start qualification,
// centre sampling of data and stop bits, one-cycle byte / framing strobes.
module uart_rx_byte
    import boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                rx,
    output logic [BYTE_W-1:0]   byte_data,
    output logic                byte_valid,
    output logic                frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t          rx_state, rx_next;
    logic               sync1, sync2, prev;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2:0]         bit_idx, bit_n;
    logic [BYTE_W-1:0]  shreg, sh_n;
    logic               valid_n, ferr_n;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            prev       <= 1'b1;
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= rx;
            sync2      <= sync1;
            prev       <= sync2;
            rx_state   <= rx_next;
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            shreg      <= sh_n;
            byte_valid <= valid_n;
            frame_err  <= ferr_n;
        end
    end

    always_comb begin
        rx_next = rx_state;
        cnt_n   = (cnt == '0) ? '0 : cnt - 1'b1;
        bit_n   = bit_idx;
        sh_n    = shreg;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (prev && !sync2) begin
                    rx_next = RX_START;
                    cnt_n   = HALF_LOAD;
                end
            end
            RX_START: begin
                // A start bit that is no longer low at half-bit is a glitch.
                if (cnt == '0) begin
                    if (!sync2) begin
                        rx_next = RX_BITS;
                        cnt_n   = FULL_LOAD;
                        bit_n   = '0;
                    end else begin
                        rx_next = RX_IDLE;
                    end
                end
            end
            RX_BITS: begin
                if (cnt == '0) begin
                    sh_n  = {sync2, shreg[BYTE_W-1:1]};
                    cnt_n = FULL_LOAD;
                    bit_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == '0) begin
                    valid_n = sync2;
                    ferr_n  = !sync2;
                    rx_next = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    assign byte_data = shreg;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed, checksummed image over 8N1 serial and
// writes it word by word to memory while holding the SoC core in reset.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_SYNC  | waiting for the sync byte, other bytes ignored
//   ST_LEN   | assembling the 4-byte little-endian word count
//   ST_DATA  | assembling the next 4-byte little-endian data word
//   ST_WRITE | wr_valid held until wr_ready; any byte here is an overrun
//   ST_CSUM  | comparing the received byte with the running sum
//   ST_DONE  | image accepted, SoC released, bytes ignored until reset
//   ST_ERR   | load failed; a sync byte restarts at ST_LEN
module uart_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int          CLK_FREQ_HZ = 12000000,
    parameter int          BAUD        = 115200,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          MAX_WORDS   = 4096
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               uart_rx,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [WORD_W-1:0]  wr_addr,
    output logic [WORD_W-1:0]  wr_data,
    output logic               soc_hold,
    output logic               load_done,
    output logic               load_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid, rx_ferr;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .rx         (uart_rx),
        .byte_data  (rx_data),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr)
    );

    state_t            state, state_n;
    logic [WORD_W-1:0] asm_word, asm_n;
    logic [1:0]        byte_idx, idx_n;
    logic [WORD_W-1:0] word_count, cnt_n;
    logic [WORD_W-1:0] words_done, done_n;
    logic [CSUM_W-1:0] csum, csum_n;
    logic [WORD_W-1:0] addr_n, data_n;
    logic [WORD_W-1:0] new_word;
    logic              last_byte;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_SYNC;
            asm_word   <= '0;
            byte_idx   <= '0;
            word_count <= '0;
            words_done <= '0;
            csum       <= '0;
            wr_addr    <= BASE_ADDR;
            wr_data    <= '0;
        end else begin
            state      <= state_n;
            asm_word   <= asm_n;
            byte_idx   <= idx_n;
            word_count <= cnt_n;
            words_done <= done_n;
            csum       <= csum_n;
            wr_addr    <= addr_n;
            wr_data    <= data_n;
        end
    end

    // Bytes arrive LSB first, so each new byte enters at the top.
    assign new_word  = {rx_data, asm_word[WORD_W-1:BYTE_W]};
    assign last_byte = (byte_idx == 2'(LEN_BYTES - 1));

    always_comb begin
        state_n = state;
        asm_n   = asm_word;
        idx_n   = byte_idx;
        cnt_n   = word_count;
        done_n  = words_done;
        csum_n  = csum;
        addr_n  = wr_addr;
        data_n  = wr_data;
        case (state)
            ST_SYNC: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_n = ST_LEN;
                    idx_n   = '0;
                    done_n  = '0;
                    csum_n  = '0;
                end
            end
            ST_LEN: begin
                if (rx_ferr) begin
                    state_n = ST_ERR;
                end else if (rx_valid) begin
                    asm_n = new_word;
                    idx_n = byte_idx + 2'd1;
                    if (last_byte) begin
                        cnt_n = new_word;
                        if (new_word > 32'(MAX_WORDS)) begin
                            state_n = ST_ERR;
                        end else if (new_word == '0) begin
                            state_n = ST_CSUM;
                        end else begin
                            state_n = ST_DATA;
                            addr_n  = BASE_ADDR;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (rx_ferr) begin
                    state_n = ST_ERR;
                end else if (rx_valid) begin
                    asm_n  = new_word;
                    idx_n  = byte_idx + 2'd1;
                    csum_n = csum + rx_data;
                    if (last_byte) begin
                        data_n  = new_word;
                        state_n = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // Overrun wins over a same-cycle handshake.
                if (rx_ferr || rx_valid) begin
                    state_n = ST_ERR;
                end else if (wr_ready) begin
                    addr_n  = wr_addr + ADDR_STEP;
                    done_n  = words_done + 32'd1;
                    state_n = (words_done + 32'd1 == word_count) ? ST_CSUM : ST_DATA;
                end
            end
            ST_CSUM: begin
                if (rx_ferr) begin
                    state_n = ST_ERR;
                end else if (rx_valid) begin
                    state_n = (rx_data == csum) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE: begin
                state_n = ST_DONE;
            end
            ST_ERR: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_n = ST_LEN;
                    idx_n   = '0;
                    done_n  = '0;
                    csum_n  = '0;
                end
            end
            default: state_n = ST_SYNC;
        endcase
    end

    assign wr_valid  = (state == ST_WRITE);
    assign soc_hold  = (state != ST_DONE);
    assign load_done = (state == ST_DONE);
    assign load_err  = (state == ST_ERR);

endmodule
